// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory: round-robin on ties,
// optional locked ownership bounded by MAXHOLD, and range checking with an error pulse.
module mem_arbiter #(
    parameter int DBITS   = 16,
    parameter int ABITS   = 12,
    parameter int MAXHOLD = 8,
    localparam int HW     = $clog2(MAXHOLD) + 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic             LOCK0,
    input  logic             LOCK1,
    input  logic             WE0,
    input  logic             WE1,
    input  logic [DBITS-1:0] ADDR0,
    input  logic [DBITS-1:0] ADDR1,
    input  logic [DBITS-1:0] WDATA0,
    input  logic [DBITS-1:0] WDATA1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             RVALID0,
    output logic             RVALID1,
    output logic [DBITS-1:0] RDATA0,
    output logic [DBITS-1:0] RDATA1,
    output logic [ABITS-1:0] MADDR,
    output logic [DBITS-1:0] MDIN,
    output logic             MWE,
    input  logic [DBITS-1:0] MDOUT,
    output logic             ERR,
    output logic [1:0]       dbg_state_o,
    output logic             dbg_last_o,
    output logic [HW-1:0]    dbg_hold_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            rv0_q, rv1_q, oor_q, err_q;
    logic            gnt0, gnt1, granted, other_req, in_range;
    logic [DBITS-1:0] sel_addr;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, ADDR0[0], ADDR1[0]};

    // Grants are combinational and suppressed while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RESET_N) begin
            if (REQ0 && !REQ1) begin
                gnt0 = 1'b1;
            end else if (REQ1 && !REQ0) begin
                gnt1 = 1'b1;
            end else if (REQ0 && REQ1) begin
                case (state_q)
                    OWN0:    if (hold_q == HOLD_MAX) gnt1 = 1'b1; else gnt0 = 1'b1;
                    OWN1:    if (hold_q == HOLD_MAX) gnt0 = 1'b1; else gnt1 = 1'b1;
                    default: if (last_q) gnt0 = 1'b1; else gnt1 = 1'b1;
                endcase
            end
        end
    end

    assign granted   = gnt0 | gnt1;
    assign other_req = gnt0 ? REQ1 : REQ0;
    assign sel_addr  = gnt1 ? ADDR1 : ADDR0;
    assign in_range  = (sel_addr[DBITS-1:ABITS+1] == '0);

    assign GNT0  = gnt0;
    assign GNT1  = gnt1;
    assign MADDR = sel_addr[ABITS:1];
    assign MDIN  = gnt1 ? WDATA1 : WDATA0;
    assign MWE   = granted && in_range && (gnt1 ? WE1 : WE0);

    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        hold_d  = '0;
        if (gnt0) begin
            state_d = LOCK0 ? OWN0 : IDLE;
            last_d  = 1'b0;
        end else if (gnt1) begin
            state_d = LOCK1 ? OWN1 : IDLE;
            last_d  = 1'b1;
        end
        // Count only repeated grants to the same owner while the other side waits.
        if (granted && state_q != IDLE && gnt1 == last_q && other_req) begin
            hold_d = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            rv0_q   <= gnt0 && !WE0;
            rv1_q   <= gnt1 && !WE1;
            oor_q   <= granted && !in_range;
            err_q   <= granted && !in_range;
        end
    end

    assign RVALID0     = rv0_q;
    assign RVALID1     = rv1_q;
    assign RDATA0      = (rv0_q && !oor_q) ? MDOUT : '0;
    assign RDATA1      = (rv1_q && !oor_q) ? MDOUT : '0;
    assign ERR         = err_q;
    assign dbg_state_o = state_q;
    assign dbg_last_o  = last_q;
    assign dbg_hold_o  = hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed arbitration scenarios plus a randomized round-robin
// phase, with read data checked against a reference memory through an expected queue.
module tb_mem_arbiter;

    logic        CLK, RESET_N;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        GNT0, GNT1, RVALID0, RVALID1, MWE, ERR;
    logic [15:0] RDATA0, RDATA1, MDIN, mdout;
    logic [11:0] MADDR;
    logic [1:0]  dbg_state;
    logic        dbg_last;
    logic [3:0]  dbg_hold;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] e0, e1;
    logic        err_exp, exp_last;
    int          n_checks = 0;
    int          n_pass = 0;

    mem_arbiter #(.DBITS(16), .ABITS(12), .MAXHOLD(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ0(req0), .REQ1(req1), .LOCK0(lock0), .LOCK1(lock1),
        .WE0(we0), .WE1(we1), .ADDR0(addr0), .ADDR1(addr1),
        .WDATA0(wdata0), .WDATA1(wdata1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .MADDR(MADDR), .MDIN(MDIN), .MWE(MWE), .MDOUT(mdout), .ERR(ERR),
        .dbg_state_o(dbg_state), .dbg_last_o(dbg_last), .dbg_hold_o(dbg_hold)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 37 + 16'h1234);
    endfunction

    function automatic logic in_rng(input logic [15:0] a);
        return a[15:13] == 3'b000;
    endfunction

    // Synchronous memory model: one-cycle read latency.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
        forever begin
            @(posedge CLK);
            if (MWE) mem[MADDR] <= MDIN;
            mdout <= mem[MADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Read-return monitor: a pending expectation must be answered at this very negedge.
    always @(negedge CLK) begin
        if (exp_q0.size() != 0 || RVALID0) begin
            check("rvalid0", RVALID0, exp_q0.size() != 0);
            if (exp_q0.size() != 0) begin
                e0 = exp_q0.pop_front();
                check("rdata0", RDATA0, e0);
            end
        end else begin
            check("rdata0_idle", RDATA0, 0);
        end
        if (exp_q1.size() != 0 || RVALID1) begin
            check("rvalid1", RVALID1, exp_q1.size() != 0);
            if (exp_q1.size() != 0) begin
                e1 = exp_q1.pop_front();
                check("rdata1", RDATA1, e1);
            end
        end else begin
            check("rdata1_idle", RDATA1, 0);
        end
    end

    // One bus cycle: check grant-cycle outputs, update the reference, queue read results.
    task automatic step(input logic eg0, input logic eg1);
        logic mwe_exp;
        @(negedge CLK);
        check("gnt0", GNT0, eg0);
        check("gnt1", GNT1, eg1);
        check("err", ERR, err_exp);
        mwe_exp = (eg0 && we0 && in_rng(addr0)) || (eg1 && we1 && in_rng(addr1));
        check("mwe", MWE, mwe_exp);
        if (eg1) begin
            check("maddr", MADDR, addr1[12:1]);
            check("mdin", MDIN, wdata1);
        end else begin
            check("maddr", MADDR, addr0[12:1]);
            check("mdin", MDIN, wdata0);
        end
        err_exp = (eg0 && !in_rng(addr0)) || (eg1 && !in_rng(addr1));
        if (eg0 && we0 && in_rng(addr0)) ref_mem[addr0[12:1]] = wdata0;
        if (eg1 && we1 && in_rng(addr1)) ref_mem[addr1[12:1]] = wdata1;
        if (eg0) exp_last = 1'b0;
        if (eg1) exp_last = 1'b1;
        @(posedge CLK);
        #1;
        if (eg0 && !we0) exp_q0.push_back(in_rng(addr0) ? ref_mem[addr0[12:1]] : 16'h0);
        if (eg1 && !we1) exp_q1.push_back(in_rng(addr1) ? ref_mem[addr1[12:1]] : 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, GNT0, 0);
        check({tag, "_gnt1"}, GNT1, 0);
        check({tag, "_mwe"}, MWE, 0);
        check({tag, "_err"}, ERR, 0);
        check({tag, "_rv0"}, RVALID0, 0);
        check({tag, "_rv1"}, RVALID1, 0);
        check({tag, "_state"}, dbg_state, 0);
        check({tag, "_last"}, dbg_last, 1);
        check({tag, "_hold"}, dbg_hold, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        err_exp = 1'b0;
        exp_last = 1'b1;
        RESET_N = 1'b0;
        req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 1'b1; we1 = 1'b1;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;

        // Reset holds grants and write enable low even with requests present.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("rst");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0010; addr1 = 16'h0020;

        // First tie after reset goes to port 0, then port 1.
        step(1, 0);
        req0 = 1'b0;
        step(0, 1);
        req1 = 1'b0;
        step(0, 0);

        // Locked write stream from port 0 against a waiting port 1.
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b1;
        req1 = 1'b1; addr1 = 16'h0030;
        for (int i = 0; i < 9; i++) begin
            addr0 = 16'h0100 + 16'(2 * i);
            wdata0 = 16'($urandom_range(0, 16'hFFFF));
            step(1, 0);
            check("hold_cnt", dbg_hold, i);
            check("own0", dbg_state, 1);
        end
        step(0, 1);
        check("hold_clr", dbg_hold, 0);
        check("idle_after_switch", dbg_state, 0);
        check("last_switch", dbg_last, 1);
        req1 = 1'b0; req0 = 1'b0; lock0 = 1'b0; we0 = 1'b0;
        step(0, 0);
        req0 = 1'b1; addr0 = 16'h0100;
        step(1, 0);
        addr0 = 16'h0110;
        step(1, 0);
        req0 = 1'b0;

        // Out-of-range write and read on port 1.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h4000; wdata1 = 16'hBEEF;
        step(0, 1);
        we1 = 1'b0;
        step(0, 1);
        req1 = 1'b0;
        req0 = 1'b1; addr0 = 16'h0000;
        step(1, 0);
        req0 = 1'b0;

        // Owner drops request: other port takes over in the same cycle.
        req0 = 1'b1; lock0 = 1'b1; addr0 = 16'h0040;
        step(1, 0);
        check("own0_lock", dbg_state, 1);
        req0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b1; lock1 = 1'b1; addr1 = 16'h0050;
        step(0, 1);
        check("own1_lock", dbg_state, 2);
        req0 = 1'b1;
        step(0, 1);
        check("own1_hold", dbg_hold, 1);
        lock1 = 1'b0;
        step(0, 1);
        check("own1_release", dbg_state, 0);
        req1 = 1'b0;
        step(1, 0);
        req1 = 1'b1;
        step(0, 1);
        req1 = 1'b0;
        step(1, 0);
        req0 = 1'b0;

        // Randomized ties in IDLE alternate every cycle, reads and writes mixed.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            addr0 = (i % 4 == 0) ? 16'($urandom_range(0, 16'hFFFF)) : 16'($urandom_range(0, 16'h1FFF));
            addr1 = (i % 5 == 0) ? 16'($urandom_range(0, 16'hFFFF)) : 16'($urandom_range(0, 16'h1FFF));
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wdata0 = 16'($urandom_range(0, 16'hFFFF));
            wdata1 = 16'($urandom_range(0, 16'hFFFF));
            step(exp_last, !exp_last);
        end
        req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;

        // Read granted just before reset asserts: no RVALID, port 0 wins the next tie.
        addr0 = 16'h0060;
        @(negedge CLK);
        check("pre_rst_gnt0", GNT0, 1);
        check("pre_rst_gnt1", GNT1, 0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        err_exp = 1'b0;
        exp_last = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        check("midrst_rv0", RVALID0, 0);
        req0 = 1'b0;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0070; addr1 = 16'h0080;
        step(1, 0);
        req0 = 1'b0;
        step(0, 1);
        req1 = 1'b0;
        step(0, 0);
        step(0, 0);

        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DBITS, default 16, data and address width.
REQ-002 Parameter ABITS, default 12, memory word-address width; byte address bits [ABITS:1] select the word.
REQ-003 Parameter MAXHOLD, default 8, maximum consecutive locked grants to one port while the other port is requesting.
REQ-004 CLK  in  1  single clock; all state changes on posedge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 REQ0/REQ1  in  1  port request, held until GNTx is seen.
REQ-007 LOCK0/LOCK1  in  1  requester asks to keep ownership for its next request.
REQ-008 WE0/WE1  in  1  1 = write, 0 = read.
REQ-009 ADDR0/ADDR1  in  DBITS  byte address.
REQ-010 WDATA0/WDATA1  in  DBITS  write data.
REQ-011 GNT0/GNT1  out  1  transaction accepted this cycle.
REQ-012 RVALID0/RVALID1  out  1  read data valid.
REQ-013 RDATA0/RDATA1  out  DBITS  read data.
REQ-014 MADDR  out  ABITS  memory word address.
REQ-015 MDIN  out  DBITS  memory write data.
REQ-016 MWE  out  1  memory write enable.
REQ-017 MDOUT  in  DBITS  memory read data, synchronous, valid one cycle after address.
REQ-018 ERR  out  1  one-cycle pulse for an out-of-range access.

Function
REQ-019 The FSM has states IDLE, OWN0, OWN1 plus registers LAST (last port granted), HOLDCNT (log2(MAXHOLD)+1 bits), and the read-return tags.
REQ-020 At most one GNT is high per cycle, and the grant is combinational from the current REQs and registered state.
REQ-021 With a single requester, that port is granted in the same cycle in any state.
REQ-022 With both requesting in IDLE, the port != LAST is granted (round-robin).
REQ-023 In OWNx with REQx high, port x is granted unless the other port requests and HOLDCNT == MAXHOLD, in which case the other port is granted.
REQ-024 On a grant to port x with LOCKx high, next state is OWNx; otherwise next state is IDLE.
REQ-025 HOLDCNT increments on consecutive grants to the same port while the other port requests, saturates at MAXHOLD, and clears to 0 on a grant to a different port or in IDLE.
REQ-026 On each grant, LAST is updated to the granted port.
REQ-027 If the owner drops REQ while in OWNx, the state returns to IDLE that cycle and the other port is granted per REQ-021.
REQ-028 MADDR = ADDRx[ABITS:1], MDIN = WDATAx, and MWE = WEx, all from the granted port in the grant cycle.
REQ-029 Without a grant, MWE = 0 and MADDR/MDIN hold port 0 values.
REQ-030 An in-range address satisfies ADDR[DBITS-1:ABITS+1] == 0.
REQ-031 An out-of-range access is still granted, with MWE forced to 0 and ERR pulsed high on the following cycle.
REQ-032 A granted read gives RVALIDx = 1 exactly one cycle later, with RDATAx = MDOUT, or 0 if out of range.
REQ-033 RDATAx = 0 whenever RVALIDx = 0.
REQ-034 A granted write produces no RVALID.
REQ-035 Back-to-back reads, alternating ports, are supported at one per cycle.

Reset
REQ-036 RESET_N low immediately forces state IDLE, LAST = 1, HOLDCNT = 0, RVALID0/1 = 0, and ERR = 0.
REQ-037 While RESET_N is low, GNT0/1 = 0 and MWE = 0.
REQ-038 A read granted in the cycle before reset asserts never produces RVALID.
REQ-039 The first tie after reset is won by port 0.

Verification
REQ-040 Reset release, then REQ0=REQ1=1 reads at 0x0010/0x0020 -> GNT0 cycle 1 and GNT1 cycle 2; RVALID0 with mem[8] in cycle 2, RVALID1 with mem[16] in cycle 3.
REQ-041 Port 0 LOCK0=1 streaming writes while REQ1=1 (MAXHOLD=8) -> 9 consecutive GNT0 (1 unlocked entry plus 8 held), then GNT1, with HOLDCNT=0 after the switch.
REQ-042 Port 1 write 0xBEEF to 0x4000 -> GNT1=1, MWE=0, ERR=1 the next cycle, memory unchanged; a subsequent read of 0x4000 returns RDATA1=0 with RVALID1=1.
REQ-043 Port 0 owns via LOCK0, then drops REQ0 while REQ1=1 -> GNT1 the same cycle, state IDLE, then OWN1 if LOCK1=1.
REQ-044 Port 0 read granted, RESET_N pulsed low mid-cycle -> no RVALID0, all outputs at reset values, and the next tie is granted to port 0.
